// File: rtl/alu_stim_seq.sv
// Table-driven stimulus sequencer for the R/S ALU slice: replays a loaded vector table over vld/rdy.
// Optional golden-model checker is compiled in with ALU_STIM_CHECK_EN.
module alu_stim_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int VW = 2*WIDTH + 3
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VW-1:0]    wr_data,
  input  logic             start,
  input  logic [AW:0]      len,
  input  logic [7:0]       loops,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] S,
  output logic             CI,
  output logic [1:0]       ALB_MI,
  output logic             vld,
  input  logic             rdy,
`ifdef ALU_STIM_CHECK_EN
  input  logic [WIDTH-1:0] res_in,
  input  logic             co_in,
  output logic             err,
  output logic [15:0]      err_cnt,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: a vector transfers on any rising edge where vld && rdy; while vld && !rdy the
  // vector outputs hold, and vld never drops without a transfer except on leaving RUN or reset.

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [VW-1:0]      table_q [DEPTH];
  logic [AW-1:0]      idx_q, idx_nxt;
  logic [7:0]         pass_q;
  logic [AW:0]        len_q, len_eff;
  logic [7:0]         loops_q, loops_eff;
  logic               hs, wrap, last_vec;
  logic [VW-1:0]      rd_vec;

  always_comb begin
    len_eff   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    loops_eff = (loops == 8'd0) ? 8'd1 : loops;
    hs        = vld && rdy;
    wrap      = ({1'b0, idx_q} == len_q - (AW+1)'(1));
    last_vec  = wrap && (pass_q == loops_q - 8'd1);
    idx_nxt   = wrap ? '0 : idx_q + AW'(1);
    // First cycle of RUN primes the outputs from idx; afterwards read ahead to the next entry.
    rd_vec    = vld ? table_q[idx_nxt] : table_q[idx_q];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (len_eff == '0) ? DONE : RUN;
      RUN:  if (hs && last_vec) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Table is deliberately not reset; it is only writable while idle.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) table_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      idx_q   <= '0;
      pass_q  <= '0;
      len_q   <= '0;
      loops_q <= '0;
      R       <= '0;
      S       <= '0;
      CI      <= 1'b0;
      ALB_MI  <= 2'b00;
      vld     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len_eff;
            loops_q <= loops_eff;
            idx_q   <= '0;
            pass_q  <= '0;
          end
        end
        RUN: begin
          if (!vld) begin
            {R, S, CI, ALB_MI} <= rd_vec;
            vld                <= 1'b1;
          end else if (hs) begin
            if (last_vec) begin
              vld <= 1'b0;
            end else begin
              idx_q              <= idx_nxt;
              {R, S, CI, ALB_MI} <= rd_vec;
              if (wrap) pass_q <= pass_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

`ifdef ALU_STIM_CHECK_EN
  logic [WIDTH:0] exp_sum;
  logic           mism;

  // Logic ops produce no carry; arithmetic ops take carry from bit WIDTH.
  always_comb begin
    exp_sum = '0;
    case (ALB_MI)
      2'b00:   exp_sum = {1'b0, R & S};
      2'b01:   exp_sum = {1'b0, R} + {1'b0, S} + {{WIDTH{1'b0}}, CI};
      2'b10:   exp_sum = {1'b0, S} + {1'b0, ~R} + {{WIDTH{1'b0}}, CI};
      default: exp_sum = {1'b0, R ^ S};
    endcase
    mism = hs && ((res_in != exp_sum[WIDTH-1:0]) || (co_in != exp_sum[WIDTH]));
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= mism;
      if (mism && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_stim_seq.sv
// Directed bench for alu_stim_seq: vector order, stalls, multi-pass, len=0, idle-only writes,
// mid-run reset, and (with ALU_STIM_CHECK_EN) the mismatch checker.
module tb_alu_stim_seq;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int VW    = 2*WIDTH + 3;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [VW-1:0]    wr_data = '0;
  logic             start = 1'b0;
  logic [AW:0]      len = '0;
  logic [7:0]       loops = '0;
  logic             busy, done;
  logic [WIDTH-1:0] R, S;
  logic             CI;
  logic [1:0]       ALB_MI;
  logic             vld;
  logic             rdy = 1'b0;
  logic [1:0]       state_dbg;

  logic [VW-1:0]    exp_q[$];
  int               total = 0;
  int               bad = 0;

`ifdef ALU_STIM_CHECK_EN
  logic [WIDTH-1:0] res_in;
  logic             co_in;
  logic             err;
  logic [15:0]      err_cnt;
  logic             fault_en = 1'b0;
  int               err_pulses = 0;
  logic [WIDTH:0]   alu_sum;

  // Stand-in combinational ALU; fault_en corrupts the 0x63+0xA5+1 result to 0x0A.
  always_comb begin
    alu_sum = '0;
    case (ALB_MI)
      2'b00:   alu_sum = {1'b0, R & S};
      2'b01:   alu_sum = {1'b0, R} + {1'b0, S} + {8'd0, CI};
      2'b10:   alu_sum = {1'b0, S} - {1'b0, R} - 9'd1 + {8'd0, CI} + 9'h100;
      default: alu_sum = {1'b0, R ^ S};
    endcase
    res_in = alu_sum[WIDTH-1:0];
    co_in  = (ALB_MI == 2'b01 || ALB_MI == 2'b10) ? alu_sum[WIDTH] : 1'b0;
    if (fault_en && ALB_MI == 2'b01 && R == 8'h63) res_in = 8'h0A;
  end

  always @(negedge clk) if (err === 1'b1) err_pulses++;
`endif

  alu_stim_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetb(resetb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .loops(loops), .busy(busy), .done(done),
    .R(R), .S(S), .CI(CI), .ALB_MI(ALB_MI), .vld(vld), .rdy(rdy),
`ifdef ALU_STIM_CHECK_EN
    .res_in(res_in), .co_in(co_in), .err(err), .err_cnt(err_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [7:0] r, input logic [7:0] s, input logic ci,
                               input logic [1:0] op);
    exp_q.push_back({r, s, ci, op});
  endfunction

  task automatic write_vec(input int addr, input logic [7:0] r, input logic [7:0] s,
                           input logic ci, input logic [1:0] op);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = {r, s, ci, op};
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Starts a replay and scores every presented vector against exp_q; the cycle count is
  // the number of clock edges from the start edge to the edge that raises done.
  task automatic run_seq(input string tag, input int ln, input int lp, input int stall_v,
                         input int stall_n, input int exp_cyc, input bit mid_wr);
    int            cyc, vcount, stalls;
    bit            seen_done, vld_seen;
    logic [VW-1:0] last_v, obs_v;
    stalls = stall_n; vcount = 0; seen_done = 0; vld_seen = 0; last_v = '0;
    if (mid_wr) begin
      wr_addr = AW'(2);
      wr_data = '1;
    end
    len = (AW+1)'(ln); loops = 8'(lp); start = 1'b1; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; cyc = 0;
    while (!seen_done && cyc < 200) begin
      wr_en = mid_wr && (cyc == 2);
      if (vld) begin
        vld_seen = 1;
        obs_v = {R, S, CI, ALB_MI};
        if (exp_q.size() == 0) begin
          total++; bad++;
          $error("FAIL %s_extra_vec observed=%0h expected=none", tag, obs_v);
          rdy = 1'b1;
        end else begin
          chk($sformatf("%s_vec%0d", tag, vcount), 32'(obs_v), 32'(exp_q[0]));
          last_v = exp_q[0];
          if (vcount == stall_v && stalls > 0) begin
            rdy = 1'b0;
            stalls--;
          end else begin
            rdy = 1'b1;
            void'(exp_q.pop_front());
            vcount++;
          end
        end
      end else begin
        rdy = 1'b1;
      end
      if (done) seen_done = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    wr_en = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
    if (ln == 0) chk({tag, "_vld_seen"}, 32'(vld_seen), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse_len"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_vld_after"}, 32'(vld), 32'd0);
    if (ln != 0) chk({tag, "_hold_last"}, 32'({R, S, CI, ALB_MI}), 32'(last_v));
    exp_q.delete();
  endtask

  task automatic push_base();
    push(8'h63, 8'hA5, 1'b0, 2'b00);
    push(8'h63, 8'hA5, 1'b1, 2'b01);
    push(8'h63, 8'hA5, 1'b1, 2'b10);
    push(8'h63, 8'hA5, 1'b0, 2'b11);
  endtask

  task automatic load_base();
    write_vec(0, 8'h63, 8'hA5, 1'b0, 2'b00);
    write_vec(1, 8'h63, 8'hA5, 1'b1, 2'b01);
    write_vec(2, 8'h63, 8'hA5, 1'b1, 2'b10);
    write_vec(3, 8'h63, 8'hA5, 1'b0, 2'b11);
  endtask

  initial begin
    int done_seen;
    // Reset values
    @(negedge clk);
    chk("rst_vec", 32'({R, S, CI, ALB_MI}), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef ALU_STIM_CHECK_EN
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    resetb = 1'b1;
    @(negedge clk);

    // Four ops back to back, done 5 edges after start
    load_base();
    push_base();
    run_seq("basic", 4, 1, -1, 0, 5, 1'b0);

    // Three-cycle stall on vector 1
    push_base();
    run_seq("stall", 4, 1, 1, 3, 8, 1'b0);

    // Two vectors, three passes; entry 1 written in the same cycle as start
    write_vec(0, 8'h0F, 8'hF0, 1'b1, 2'b01);
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = {8'h0F, 8'hF0, 1'b1, 2'b10};
    for (int i = 0; i < 3; i++) begin
      push(8'h0F, 8'hF0, 1'b1, 2'b01);
      push(8'h0F, 8'hF0, 1'b1, 2'b10);
    end
    run_seq("loops", 2, 3, -1, 0, 7, 1'b0);

    // Zero length: immediate done, no vectors
    run_seq("len0", 0, 5, -1, 0, 0, 1'b0);

    // loops=0 acts as 1; a write during RUN must not reach the table
    load_base();
    push_base();
    run_seq("wr_in_run", 4, 0, -1, 0, 5, 1'b1);
    push_base();
    run_seq("replay", 4, 1, -1, 0, 5, 1'b0);

`ifdef ALU_STIM_CHECK_EN
    chk("clean_err_cnt", 32'(err_cnt), 32'd0);
    chk("clean_err_pulses", 32'(err_pulses), 32'd0);
`endif

    // Asynchronous reset mid-run
    len = 5'd4; loops = 8'd3; start = 1'b1; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_vld_before", 32'(vld), 32'd1);
    #2 resetb = 1'b0;
    #1;
    chk("midrst_vec", 32'({R, S, CI, ALB_MI}), 32'd0);
    chk("midrst_vld", 32'(vld), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    resetb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    push_base();
    run_seq("restart", 4, 1, -1, 0, 5, 1'b0);

`ifdef ALU_STIM_CHECK_EN
    // Corrupted result on vector 1
    err_pulses = 0;
    fault_en = 1'b1;
    push_base();
    run_seq("fault", 4, 1, -1, 0, 5, 1'b0);
    fault_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("fault_err_pulses", 32'(err_pulses), 32'd1);
    chk("fault_err_cnt", 32'(err_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
